mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum wait cycles for mem_ack before error, range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk input 1: single clock; all state changes on the rising edge.
REQ-004 rst input 1: reset, asynchronous, active-low.
REQ-005 memread, memwrite input 1 each: MEM-stage controls from the EX/MEM register outputs.
REQ-006 aluresult input 32: access address.
REQ-007 wdata input 32: store data.
REQ-008 rd input 5: destination register of the MEM-stage instruction.
REQ-009 mem_req output 1: data-memory request.
REQ-010 mem_we output 1: store access when mem_req=1.
REQ-011 mem_addr output 32: address to memory.
REQ-012 mem_wdata output 32: store data to memory.
REQ-013 mem_ack input 1: memory completion for the current request.
REQ-014 mem_rdata input 32: load data, valid when mem_ack=1.
REQ-015 stall output 1: freezes PC, IF/ID, ID/EX and EX/MEM; when asserted, MEM/WB receives a bubble.
REQ-016 ld_valid output 1: registered one-cycle pulse, load data available.
REQ-017 ld_data output 32: registered load data.
REQ-018 ld_rd output 5: registered load destination.
REQ-019 err output 1: sticky access-timeout flag.
REQ-020 stall_cnt output CNT_W: count of stall cycles.

Function
REQ-021 op = memread | memwrite; memread=memwrite=1 is treated as a load (mem_we=0).
REQ-022 FSM states: IDLE, WAIT, ERR.
REQ-023 mem_req = op when in IDLE or WAIT, and 0 in ERR; mem_req is combinational.
REQ-024 mem_we = memwrite & ~memread; mem_addr = aluresult; mem_wdata = wdata; all are combinational pass-through.
REQ-025 stall = mem_req & ~mem_ack; in ERR, stall = 1.
REQ-026 IDLE -> WAIT when op=1 and mem_ack=0.
REQ-027 IDLE stays in IDLE when op=1 and mem_ack=1 (zero-wait access, no stall).
REQ-028 WAIT -> IDLE on mem_ack=1.
REQ-029 WAIT -> ERR when wait_cnt reaches TIMEOUT-1 without mem_ack.
REQ-030 ERR is exited only by reset.
REQ-031 wait_cnt clears on entry to WAIT and increments each WAIT cycle.
REQ-032 mem_ack outside a request (mem_req=0) is ignored.
REQ-033 On the edge where mem_req & mem_ack & ~mem_we: ld_valid<=1, ld_data<=mem_rdata, ld_rd<=rd.
REQ-034 Otherwise ld_valid<=0, and ld_data and ld_rd hold their values.
REQ-035 Load latency: ld_valid is asserted the cycle after mem_ack.
REQ-036 Store completion produces no ld_valid.
REQ-037 Back-to-back operations: after an ack edge, the next EX/MEM op is evaluated in IDLE on the following cycle with no dead cycle.
REQ-038 stall_cnt increments on every cycle with stall=1 and saturates at all-ones (no wrap).
REQ-039 err<=1 on entry to ERR.

Reset
REQ-040 While rst=0, the block immediately forces: state IDLE, wait_cnt 0, ld_valid 0, ld_data 0, ld_rd 0, err 0, stall_cnt 0.
REQ-041 Reset during WAIT abandons the access; mem_req follows op once reset is released.
REQ-042 Combinational outputs are governed only by state and inputs; there is no separate reset override.

Configuration
REQ-043 Macro MEM_TIMEOUT_EN controls the timeout feature:
- Defined: REQ-029/030/039 apply.
- Undefined: the ERR state and wait_cnt are removed, WAIT waits indefinitely for mem_ack, and err is tied to 0.

Verification
REQ-044 Load, addr 0x100, mem_ack same cycle with rdata 0xDEADBEEF, rd=5 -> stall never 1; next cycle ld_valid=1, ld_data=0xDEADBEEF, ld_rd=5.
REQ-045 Store, addr 0x200, wdata 0x12345678, ack after 3 cycles -> mem_we=1 throughout; stall=1 for exactly 3 cycles; stall_cnt=3; ld_valid stays 0.
REQ-046 MEM_TIMEOUT_EN defined, TIMEOUT=4, load with no ack -> after 4 WAIT cycles state=ERR, err=1, mem_req=0, stall=1 held until rst=0.
REQ-047 Load then store back-to-back, each acked in 1 cycle -> two separate 1-cycle stalls; one ld_valid pulse only; stall_cnt=2.
REQ-048 rst pulled low mid-WAIT (cycle 2 of 5) -> all registered outputs 0 immediately; after release, a fresh request completes normally.
REQ-049 CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access controller with stall, load capture and timeout
//
// Purpose:
//   Sits between the EX/MEM pipeline register and the data memory. Issues a
//   combinational request for the MEM-stage load/store and stalls the pipeline
//   until mem_ack. It registers load data and the destination register as a
//   one-cycle ld_valid pulse, and counts stall cycles with a saturating counter.
//
// Optional feature:
//   MEM_TIMEOUT_EN - when defined, an access that waits TIMEOUT cycles in WAIT
//   without mem_ack moves to a terminal ERR state and sets the sticky err flag.
//   When undefined, WAIT waits indefinitely and err is tied low.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   memread    MEM-stage load control
//   memwrite   MEM-stage store control
//   aluresult  access address
//   wdata      store data
//   rd         MEM-stage destination register
//   mem_req    memory request (combinational)
//   mem_we     store access qualifier (combinational)
//   mem_addr   memory address (pass-through)
//   mem_wdata  memory store data (pass-through)
//   mem_ack    memory completion for the current request
//   mem_rdata  memory load data, valid with mem_ack
//   stall      pipeline freeze (PC, IF/ID, ID/EX, EX/MEM); MEM/WB takes a bubble
//   ld_valid   registered one-cycle load-data pulse
//   ld_data    registered load data
//   ld_rd      registered load destination
//   err        sticky access-timeout flag
//   stall_cnt  saturating stall-cycle counter
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [31:0]      aluresult,
  input  logic [31:0]      wdata,
  input  logic [4:0]       rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             stall,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [4:0]       ld_rd,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_access_ctrl: TIMEOUT must be in 2..255");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt, wait_cnt_nxt;
`else
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
`endif

  state_t state, state_nxt;
  logic   op;
  logic   ld_fire;

  // A simultaneous memread/memwrite is treated as a load.
  assign op        = memread | memwrite;
  assign mem_we    = memwrite & ~memread;
  assign mem_addr  = aluresult;
  assign mem_wdata = wdata;
  assign ld_fire   = mem_req & mem_ack & ~mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
      wait_cnt <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MEM_TIMEOUT_EN
      wait_cnt <= wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        mem_req = op;
        stall   = op & ~mem_ack;
        // Zero-wait accesses complete here without ever leaving IDLE.
        if (op && !mem_ack) begin
          state_nxt = S_WAIT;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        mem_req = op;
        stall   = op & ~mem_ack;
        // An ack is only meaningful while a request is outstanding.
        if (op && mem_ack) begin
          state_nxt = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
`endif
      end
`ifdef MEM_TIMEOUT_EN
      S_ERR: begin
        // Terminal: the pipeline stays frozen and no further requests issue.
        stall = 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid  <= 1'b0;
      ld_data   <= 32'd0;
      ld_rd     <= 5'd0;
      stall_cnt <= '0;
    end else begin
      ld_valid <= ld_fire;
      if (ld_fire) begin
        ld_data <= mem_rdata;
        ld_rd   <= rd;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state_nxt == S_ERR) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0, mem_ack = 1'b0;
  logic [31:0] aluresult = '0, wdata = '0, mem_rdata = '0;
  logic [4:0]  rd = '0;

  logic        mem_req, mem_we, stall, ld_valid, err;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [4:0]  ld_rd;
  logic [15:0] stall_cnt;

  logic        s_mem_req, s_mem_we, s_stall, s_ld_valid, s_err;
  logic [31:0] s_mem_addr, s_mem_wdata, s_ld_data;
  logic [4:0]  s_ld_rd;
  logic [3:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } ld_t;

  ld_t sb[$];
  ld_t obs[$];
  int  ld_pulses = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .aluresult(aluresult), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
    .err(err), .stall_cnt(stall_cnt)
  );

  mem_access_ctrl #(.TIMEOUT(255), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .aluresult(aluresult), .wdata(wdata), .rd(rd),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(s_stall), .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_rd(s_ld_rd),
    .err(s_err), .stall_cnt(s_stall_cnt)
  );

  // Observed load results, sampled mid-cycle.
  always @(negedge clk) begin
    if (ld_valid === 1'b1) begin
      obs.push_back('{ld_data, ld_rd});
      ld_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memread  = 1'b0;
    memwrite = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    obs.delete();
  endtask

  // Holds one access for waits non-ack cycles, then acks it; returns stalls seen.
  task automatic do_access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] r,
                           input logic [31:0] rdata, input int waits,
                           output int stalls, output bit we_all);
    memread   = rd_en;
    memwrite  = wr_en;
    aluresult = addr;
    wdata     = data;
    rd        = r;
    mem_rdata = rdata;
    stalls    = 0;
    we_all    = 1'b1;
    for (int c = 0; c <= waits; c++) begin
      mem_ack = (c == waits);
      @(negedge clk);
      if (stall === 1'b1) stalls++;
      if (mem_we !== 1'b1) we_all = 1'b0;
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b0;
    #1;
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL reset_ld_valid: got %0b expected 0", ld_valid); end
    checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL reset_ld_data: got %0h expected 0", ld_data); end
    checks++; if (ld_rd !== 5'd0) begin errors++; $display("FAIL reset_ld_rd: got %0d expected 0", ld_rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_req_stall: got req=%0b stall=%0b expected 0 0", mem_req, stall); end
    do_reset();
  endtask

  task automatic test_zero_wait_load();
    int st; bit we; ld_t o, e;
    do_reset();
    memread = 1'b1; memwrite = 1'b1; aluresult = 32'h100;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL zw_both_as_load: got req=%0b we=%0b addr=%0h expected 1 0 100", mem_req, mem_we, mem_addr); end
    sb.push_back('{32'hDEADBEEF, 5'd5});
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, st, we);
    idle();
    checks++; if (st != 0) begin errors++; $display("FAIL zw_stall: got %0d stall cycles expected 0", st); end
    @(negedge clk);
    checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL zw_latency: got ld_valid=%0b expected 1", ld_valid); end
    step();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL zw_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++;
    if (obs.size() != 1 || sb.size() != 1) begin
      errors++; $display("FAIL zw_sb_count: got %0d loads expected %0d", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      checks++; if (o.data !== e.data || o.rd !== e.rd) begin errors++; $display("FAIL zw_sb_data: got %0h/%0d expected %0h/%0d", o.data, o.rd, e.data, e.rd); end
    end
  endtask

  task automatic test_store_wait();
    int st, n0; bit we;
    do_reset();
    n0 = ld_pulses;
    memread = 1'b0; memwrite = 1'b1; aluresult = 32'h200; wdata = 32'h12345678;
    #1;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin errors++; $display("FAIL st_passthru: got we=%0b wdata=%0h addr=%0h expected 1 12345678 200", mem_we, mem_wdata, mem_addr); end
    do_access(1'b0, 1'b1, 32'h200, 32'h12345678, 5'd0, 32'h0, 3, st, we);
    idle();
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL st_we_held: got %0b expected 1", we); end
    checks++; if (st != 3) begin errors++; $display("FAIL st_stall_cycles: got %0d expected 3", st); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL st_stall_cnt: got %0d expected 3", stall_cnt); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL st_no_ld_valid: got %0b expected 0", ld_valid); end
    step();
    checks++; if (ld_pulses != n0 || obs.size() != 0) begin errors++; $display("FAIL st_no_load: got %0d pulses expected 0", ld_pulses - n0); end
  endtask

  task automatic test_back_to_back();
    int st1, st2, n0; bit we; ld_t o, e;
    do_reset();
    n0 = ld_pulses;
    sb.push_back('{32'hCAFEF00D, 5'd7});
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 5'd7, 32'hCAFEF00D, 1, st1, we);
    do_access(1'b0, 1'b1, 32'h304, 32'hA5A5A5A5, 5'd0, 32'h0, 1, st2, we);
    idle();
    step();
    step();
    checks++; if (st1 != 1 || st2 != 1) begin errors++; $display("FAIL b2b_stalls: got %0d,%0d expected 1,1", st1, st2); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL b2b_stall_cnt: got %0d expected 2", stall_cnt); end
    checks++; if (ld_pulses - n0 != 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", ld_pulses - n0); end
    checks++;
    if (obs.size() != 1 || sb.size() != 1) begin
      errors++; $display("FAIL b2b_sb_count: got %0d loads expected %0d", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      checks++; if (o.data !== e.data || o.rd !== e.rd) begin errors++; $display("FAIL b2b_sb_data: got %0h/%0d expected %0h/%0d", o.data, o.rd, e.data, e.rd); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int st; bit we; ld_t o, e;
    do_reset();
    sb.push_back('{32'h11223344, 5'd9});
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 5'd9, 32'h11223344, 0, st, we);
    idle();
    step();
    checks++; if (ld_data !== 32'h11223344 || ld_rd !== 5'd9) begin errors++; $display("FAIL rmw_preload: got %0h/%0d expected 11223344/9", ld_data, ld_rd); end
    if (obs.size() > 0) o = obs.pop_front();
    if (sb.size() > 0) e = sb.pop_front();
    memread = 1'b1; aluresult = 32'h500; rd = 5'd3; mem_ack = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if (ld_valid !== 1'b0 || ld_data !== 32'd0 || ld_rd !== 5'd0) begin errors++; $display("FAIL rmw_ld_regs: got %0b/%0h/%0d expected 0/0/0", ld_valid, ld_data, ld_rd); end
    checks++; if (stall_cnt !== 16'd0 || err !== 1'b0) begin errors++; $display("FAIL rmw_cnt_err: got %0d/%0b expected 0/0", stall_cnt, err); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmw_req_follows_op: got %0b expected 1", mem_req); end
    step();
    rst = 1'b1;
    sb.push_back('{32'h55AA55AA, 5'd3});
    do_access(1'b1, 1'b0, 32'h500, 32'h0, 5'd3, 32'h55AA55AA, 2, st, we);
    idle();
    step();
    checks++; if (st != 2 || stall_cnt !== 16'd2) begin errors++; $display("FAIL rmw_fresh_stall: got %0d cycles cnt=%0d expected 2 2", st, stall_cnt); end
    checks++;
    if (obs.size() != 1 || sb.size() != 1) begin
      errors++; $display("FAIL rmw_sb_count: got %0d loads expected %0d", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      checks++; if (o.data !== e.data || o.rd !== e.rd) begin errors++; $display("FAIL rmw_sb_data: got %0h/%0d expected %0h/%0d", o.data, o.rd, e.data, e.rd); end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n0;
    do_reset();
    n0 = ld_pulses;
    memread = 1'b1; memwrite = 1'b0; aluresult = 32'h600; mem_ack = 1'b0;
    repeat (4) step();
    checks++; if (err !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL to_last_wait: got err=%0b req=%0b expected 0 1", err, mem_req); end
    step();
    checks++; if (err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL to_enter_err: got err=%0b req=%0b stall=%0b expected 1 0 1", err, mem_req, stall); end
    mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    repeat (3) step();
    checks++; if (err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got err=%0b req=%0b stall=%0b expected 1 0 1", err, mem_req, stall); end
    checks++; if (ld_pulses != n0) begin errors++; $display("FAIL to_no_load: got %0d pulses expected 0", ld_pulses - n0); end
    do_reset();
    checks++; if (err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL to_reset_exit: got err=%0b stall=%0b expected 0 0", err, stall); end
  endtask
`else
  task automatic test_timeout();
    int st; bit we; ld_t o, e;
    do_reset();
    sb.push_back('{32'h0BADF00D, 5'd12});
    do_access(1'b1, 1'b0, 32'h600, 32'h0, 5'd12, 32'h0BADF00D, 40, st, we);
    idle();
    step();
    checks++; if (st != 40 || stall_cnt !== 16'd40) begin errors++; $display("FAIL nto_long_wait: got %0d cycles cnt=%0d expected 40 40", st, stall_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nto_err: got %0b expected 0", err); end
    checks++;
    if (obs.size() != 1 || sb.size() != 1) begin
      errors++; $display("FAIL nto_sb_count: got %0d loads expected %0d", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      checks++; if (o.data !== e.data || o.rd !== e.rd) begin errors++; $display("FAIL nto_sb_data: got %0h/%0d expected %0h/%0d", o.data, o.rd, e.data, e.rd); end
    end
  endtask
`endif

  task automatic test_saturation();
    int st; bit we;
    do_reset();
    do_access(1'b1, 1'b0, 32'h700, 32'h0, 5'd1, 32'h77, 20, st, we);
    idle();
    step();
    checks++; if (s_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", s_stall_cnt); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL sat_err: got %0b expected 0", s_err); end
`ifndef MEM_TIMEOUT_EN
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
